// File: rtl/regfile_vector_mlane_if.sv
// Bus between the vector issue/writeback stages and the vector register file.
// Carries the read ports, write handshake, reservations, scoreboard and clear control.
interface regfile_vector_mlane_if #(
    parameter int NUM_REGS = 32,
    parameter int LANES    = 4,
    parameter int LANE_W   = 32,
    parameter int NUM_RD   = 2
);
    localparam int AW     = $clog2(NUM_REGS);
    localparam int DATA_W = LANES * LANE_W;

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;

    // Write handshake: a write lands on the rising edge where wr_valid && wr_ready.
    // wr_valid seen while wr_ready is low is dropped, so the producer must hold
    // wr_valid and the write fields stable until that edge.
    logic                     wr_valid;
    logic                     wr_ready;
    logic [AW-1:0]            wr_addr;
    logic [LANES-1:0]         wr_mask;
    logic [DATA_W-1:0]        wr_data;

    logic                     rsv_valid;
    logic [AW-1:0]            rsv_addr;
    logic [NUM_REGS-1:0]      pending;

    logic                     clr_req;
    logic                     clr_busy;

    modport master (
        output rd_addr, wr_valid, wr_addr, wr_mask, wr_data, rsv_valid, rsv_addr, clr_req,
        input  rd_data, wr_ready, pending, clr_busy
    );

    modport slave (
        input  rd_addr, wr_valid, wr_addr, wr_mask, wr_data, rsv_valid, rsv_addr, clr_req,
        output rd_data, wr_ready, pending, clr_busy
    );
endinterface

// File: rtl/regfile_vector_mlane.sv
// Multi-port, lane-masked vector register file with write bypass, pending-write
// scoreboard and a one-entry-per-cycle clear engine (storage itself has no reset).
module regfile_vector_mlane #(
    parameter int NUM_REGS = 32,
    parameter int LANES    = 4,
    parameter int LANE_W   = 32,
    parameter int NUM_RD   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_vector_mlane_if.slave bus,
    output logic                 dbg_state
);
    localparam int AW     = $clog2(NUM_REGS);
    localparam int DATA_W = LANES * LANE_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t              state, state_nx;
    logic [AW-1:0]       clr_idx, clr_idx_nx;
    logic [NUM_REGS-1:0] pending_q, pending_nx;
    logic                fire;
    logic                clearing;

    logic [DATA_W-1:0]   mem [NUM_REGS];

    assign clearing      = (state == ST_CLEAR);
    assign bus.clr_busy  = clearing;
    assign bus.wr_ready  = (state == ST_READY);
    assign bus.pending   = pending_q;
    assign fire          = bus.wr_valid && bus.wr_ready;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            pending_q <= '0;
        end else begin
            state     <= state_nx;
            clr_idx   <= clr_idx_nx;
            pending_q <= pending_nx;
        end
    end

    // The index is compared before it wraps, so AW bits are enough.
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        pending_nx = pending_q;
        case (state)
            ST_CLEAR: begin
                clr_idx_nx = clr_idx + 1'b1;
                pending_nx = '0;
                if (clr_idx == LAST_IDX) begin
                    state_nx = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.clr_req) begin
                    state_nx   = ST_CLEAR;
                    clr_idx_nx = '0;
                    pending_nx = '0;
                end else begin
                    if (fire) begin
                        pending_nx[bus.wr_addr] = 1'b0;
                    end
                    // Applied after the clear so a same-address reservation wins.
                    if (bus.rsv_valid) begin
                        pending_nx[bus.rsv_addr] = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_CLEAR;
            end
        endcase
    end

    // Writes only fire in READY, so they never collide with the clear sweep.
    always_ff @(posedge clk) begin
        if (fire) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.wr_mask[l]) begin
                    mem[bus.wr_addr][l*LANE_W +: LANE_W] <= bus.wr_data[l*LANE_W +: LANE_W];
                end
            end
        end else if (clearing) begin
            mem[clr_idx] <= '0;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] word;

        assign addr = bus.rd_addr[p*AW +: AW];

        // Zero-forcing while clearing hides both the unreset storage and partial sweeps.
        always_comb begin
            word = mem[addr];
            if (fire && (addr == bus.wr_addr)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (bus.wr_mask[l]) begin
                        word[l*LANE_W +: LANE_W] = bus.wr_data[l*LANE_W +: LANE_W];
                    end
                end
            end
            if (clearing) begin
                word = '0;
            end
        end

        assign bus.rd_data[p*DATA_W +: DATA_W] = word;
    end
endmodule

// File: tb/tb_regfile_vector_mlane.sv
// Bench for regfile_vector_mlane: directed vector table, clear/reset sequences and
// randomized traffic, all compared against a behavioural model of the register file.
module tb_regfile_vector_mlane;
    localparam int NUM_REGS = 32;
    localparam int LANES    = 4;
    localparam int LANE_W   = 32;
    localparam int NUM_RD   = 2;
    localparam int AW       = $clog2(NUM_REGS);
    localparam int DATA_W   = LANES * LANE_W;

    logic clk;
    logic rst;
    logic dbg_state;

    regfile_vector_mlane_if #(
        .NUM_REGS(NUM_REGS), .LANES(LANES), .LANE_W(LANE_W), .NUM_RD(NUM_RD)
    ) bus ();

    regfile_vector_mlane #(
        .NUM_REGS(NUM_REGS), .LANES(LANES), .LANE_W(LANE_W), .NUM_RD(NUM_RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents, scoreboard and remaining clear cycles.
    logic [DATA_W-1:0]   m_mem [NUM_REGS];
    logic [NUM_REGS-1:0] m_pend;
    int                  m_left;

    logic [AW-1:0] ra [NUM_RD];

    typedef struct {
        logic                wr_valid;
        logic [AW-1:0]       wr_addr;
        logic [LANES-1:0]    wr_mask;
        logic [DATA_W-1:0]   wr_data;
        logic                rsv_valid;
        logic [AW-1:0]       rsv_addr;
        logic [AW-1:0]       ra0;
        logic [AW-1:0]       ra1;
        logic [DATA_W-1:0]   exp0;
        logic [DATA_W-1:0]   exp1;
        logic [NUM_REGS-1:0] exp_pend;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [AW-1:0] a);
        logic [DATA_W-1:0] w;
        if (m_left > 0) return '0;
        w = m_mem[a];
        if (bus.wr_valid && a == bus.wr_addr) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.wr_mask[l]) w[l*LANE_W +: LANE_W] = bus.wr_data[l*LANE_W +: LANE_W];
            end
        end
        return w;
    endfunction

    task automatic model_clear();
        m_left = NUM_REGS;
        m_pend = '0;
        for (int r = 0; r < NUM_REGS; r++) m_mem[r] = '0;
    endtask

    // Applied with the inputs that were stable across the rising edge.
    task automatic model_step();
        if (rst) begin
            model_clear();
        end else if (m_left > 0) begin
            m_left--;
        end else if (bus.clr_req) begin
            model_clear();
        end else begin
            if (bus.wr_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    if (bus.wr_mask[l])
                        m_mem[bus.wr_addr][l*LANE_W +: LANE_W] = bus.wr_data[l*LANE_W +: LANE_W];
                end
                m_pend[bus.wr_addr] = 1'b0;
            end
            if (bus.rsv_valid) m_pend[bus.rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("clr_busy", DATA_W'(bus.clr_busy), DATA_W'(m_left > 0));
        check("wr_ready", DATA_W'(bus.wr_ready), DATA_W'(m_left == 0));
        check("dbg_state", DATA_W'(dbg_state), DATA_W'(m_left == 0));
        check("pending", DATA_W'(bus.pending), DATA_W'(m_pend));
        for (int p = 0; p < NUM_RD; p++) begin
            check($sformatf("rd_data%0d", p), bus.rd_data[p*DATA_W +: DATA_W], model_read(ra[p]));
        end
    endtask

    // Driver: inputs are set at the falling edge; outputs are checked 1 ns later.
    task automatic cycle();
        for (int p = 0; p < NUM_RD; p++) bus.rd_addr[p*AW +: AW] = ra[p];
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_mask   = '0;
        bus.wr_data   = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        bus.clr_req   = 1'b0;
        for (int p = 0; p < NUM_RD; p++) ra[p] = '0;
    endtask

    // Counts busy cycles until READY, optionally pulsing clr_req at one of them.
    task automatic wait_clear(input string name, input int pulse_at);
        int n = 0;
        while (bus.clr_busy === 1'b1 && n < 200) begin
            bus.clr_req = (n == pulse_at);
            if (bus.wr_valid) begin
                bus.wr_addr = AW'($urandom_range(0, NUM_REGS - 1));
                bus.wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            cycle();
            n++;
        end
        bus.clr_req = 1'b0;
        check(name, DATA_W'(n), DATA_W'(NUM_REGS));
    endtask

    localparam logic [DATA_W-1:0] D1  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [DATA_W-1:0] DA  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [DATA_W-1:0] R5  = 128'h44444444_AAAAAAAA_22222222_AAAAAAAA;
    localparam logic [DATA_W-1:0] D7  = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [DATA_W-1:0] D8  = 128'h88888888_88888888_88888888_88888888;
    localparam logic [DATA_W-1:0] DBF = 128'h11111111_22222222_DEADBEEF_33333333;
    localparam logic [DATA_W-1:0] R7  = 128'h0000000D_0000000C_DEADBEEF_0000000A;
    localparam logic [DATA_W-1:0] Z   = 128'h0;

    initial begin
        m_left = 0;
        m_pend = '0;
        idle_inputs();
        rst = 1'b1;

        // Reset: two cycles high, then the full-length clear.
        @(posedge clk);
        model_step();
        @(negedge clk);
        cycle();
        check("reset_pending", DATA_W'(bus.pending), Z);
        rst = 1'b0;
        wait_clear("reset_clear_len", -1);

        // Directed vectors: masked write, bypass, scoreboard set/clear priority.
        vecs[0]  = '{1'b1, 5'd5, 4'b1111, D1,  1'b0, 5'd0, 5'd5, 5'd6, D1,  Z,   32'h0};
        vecs[1]  = '{1'b1, 5'd5, 4'b0101, DA,  1'b0, 5'd0, 5'd5, 5'd5, R5,  R5,  32'h0};
        vecs[2]  = '{1'b0, 5'd0, 4'b0000, Z,   1'b0, 5'd0, 5'd5, 5'd7, R5,  Z,   32'h0};
        vecs[3]  = '{1'b1, 5'd7, 4'b1111, D7,  1'b0, 5'd0, 5'd8, 5'd7, Z,   D7,  32'h0};
        vecs[4]  = '{1'b1, 5'd8, 4'b1111, D8,  1'b0, 5'd0, 5'd8, 5'd0, D8,  Z,   32'h0};
        vecs[5]  = '{1'b1, 5'd7, 4'b0010, DBF, 1'b0, 5'd0, 5'd7, 5'd8, R7,  D8,  32'h0};
        vecs[6]  = '{1'b0, 5'd0, 4'b0000, Z,   1'b0, 5'd0, 5'd7, 5'd8, R7,  D8,  32'h0};
        vecs[7]  = '{1'b0, 5'd0, 4'b0000, Z,   1'b1, 5'd3, 5'd3, 5'd5, Z,   R5,  32'h0};
        vecs[8]  = '{1'b1, 5'd3, 4'b0000, DA,  1'b1, 5'd3, 5'd3, 5'd5, Z,   R5,  32'h8};
        vecs[9]  = '{1'b1, 5'd3, 4'b0000, DA,  1'b1, 5'd9, 5'd3, 5'd9, Z,   Z,   32'h8};
        vecs[10] = '{1'b1, 5'd9, 4'b0000, DA,  1'b1, 5'd4, 5'd4, 5'd9, Z,   Z,   32'h200};
        vecs[11] = '{1'b0, 5'd0, 4'b0000, Z,   1'b0, 5'd0, 5'd4, 5'd9, Z,   Z,   32'h10};

        for (int i = 0; i < 12; i++) begin
            bus.wr_valid  = vecs[i].wr_valid;
            bus.wr_addr   = vecs[i].wr_addr;
            bus.wr_mask   = vecs[i].wr_mask;
            bus.wr_data   = vecs[i].wr_data;
            bus.rsv_valid = vecs[i].rsv_valid;
            bus.rsv_addr  = vecs[i].rsv_addr;
            ra[0] = vecs[i].ra0;
            ra[1] = vecs[i].ra1;
            bus.rd_addr = {ra[1], ra[0]};
            #1;
            check($sformatf("vec%0d_rd0", i), bus.rd_data[0 +: DATA_W], vecs[i].exp0);
            check($sformatf("vec%0d_rd1", i), bus.rd_data[DATA_W +: DATA_W], vecs[i].exp1);
            check($sformatf("vec%0d_pending", i), DATA_W'(bus.pending), DATA_W'(vecs[i].exp_pend));
            check($sformatf("vec%0d_wr_ready", i), DATA_W'(bus.wr_ready), DATA_W'(1));
            cycle();
        end
        idle_inputs();

        // Clear mid-run: fill every register, reserve every register, then clear
        // while a writer keeps wr_valid high throughout.
        for (int r = 0; r < NUM_REGS; r++) begin
            bus.wr_valid  = 1'b1;
            bus.wr_addr   = AW'(r);
            bus.wr_mask   = '1;
            bus.wr_data   = {$urandom(), $urandom(), $urandom(), $urandom() | 32'h1};
            bus.rsv_valid = 1'b1;
            bus.rsv_addr  = AW'(r);
            ra[0] = AW'(r);
            ra[1] = AW'(NUM_REGS - 1 - r);
            cycle();
        end
        check("pending_all_set", DATA_W'(bus.pending), DATA_W'({NUM_REGS{1'b1}}));
        bus.rsv_valid = 1'b0;
        bus.clr_req   = 1'b1;
        cycle();
        bus.clr_req = 1'b0;
        bus.rsv_valid = 1'b1;
        wait_clear("clear_mid_run_len", -1);
        check("pending_after_clear", DATA_W'(bus.pending), Z);
        idle_inputs();
        for (int r = 0; r < NUM_REGS; r += 2) begin
            ra[0] = AW'(r);
            ra[1] = AW'(r + 1);
            bus.rd_addr = {ra[1], ra[0]};
            #1;
            check($sformatf("cleared_r%0d", r), bus.rd_data[0 +: DATA_W] | bus.rd_data[DATA_W +: DATA_W], Z);
            cycle();
        end

        // Reset mid-clear restarts the sweep; clr_req inside CLEAR does not extend it.
        bus.clr_req = 1'b1;
        cycle();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_clear("rst_mid_clear_len", 5);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.clr_req   = ($urandom_range(0, 99) == 0);
            bus.wr_valid  = ($urandom_range(0, 3) != 0);
            bus.wr_addr   = AW'($urandom_range(0, 7));
            bus.wr_mask   = LANES'($urandom_range(0, 15));
            bus.wr_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.rsv_valid = ($urandom_range(0, 1) == 1);
            bus.rsv_addr  = AW'($urandom_range(0, 7));
            ra[0] = ($urandom_range(0, 1) == 1) ? bus.wr_addr : AW'($urandom_range(0, 7));
            ra[1] = AW'($urandom_range(0, NUM_REGS - 1));
            cycle();
        end
        rst = 1'b0;
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
